// File: rtl/gpr_file.sv
// Architectural register file for the npc core: two bypassed combinational read
// ports, one core write port, and a handshaked debug write port with one-entry buffer.
module gpr_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wen,
    input  logic [ADDR_WIDTH-1:0]                    waddr,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    input  logic [ADDR_WIDTH-1:0]                    raddr1,
    output logic [DATA_WIDTH-1:0]                    rdata1,
    input  logic [ADDR_WIDTH-1:0]                    raddr2,
    output logic [DATA_WIDTH-1:0]                    rdata2,
    input  logic                                     dbg_valid,
    output logic                                     dbg_ready,
    input  logic [ADDR_WIDTH-1:0]                    dbg_addr,
    input  logic [DATA_WIDTH-1:0]                    dbg_data,
    output logic                                     dbg_done,
    output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0]    regfile,
    output logic [31:0]                              wr_count
);

    localparam int unsigned NREGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        PENDING
    } dbg_state_t;

    dbg_state_t            state;
    logic [DATA_WIDTH-1:0] mem [NREGS];
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;

    // Core writes win every edge; the buffered debug write drains on the first idle edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            state    <= IDLE;
            buf_addr <= '0;
            buf_data <= '0;
            dbg_done <= 1'b0;
            wr_count <= '0;
        end else begin
            dbg_done <= 1'b0;
            if (wen && (waddr != '0)) begin
                mem[waddr] <= wdata;
                wr_count   <= wr_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (dbg_valid) begin
                        buf_addr <= dbg_addr;
                        buf_data <= dbg_data;
                        state    <= PENDING;
                    end
                end
                PENDING: begin
                    if (!wen) begin
                        if (buf_addr != '0) begin
                            mem[buf_addr] <= buf_data;
                            wr_count      <= wr_count + 32'd1;
                        end
                        dbg_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_ready = rst_n && (state == IDLE);

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (wen && (waddr == addr) && (waddr != '0)) begin
            val = wdata;
        end else if (addr != '0) begin
            val = mem[addr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    // Entry 0 is driven as constant zero rather than from storage.
    always_comb begin
        regfile = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            regfile[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
        end
    end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic
// checked against an array/queue reference model.
module tb_gpr_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic              clk;
    logic              rst_n;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [AW-1:0]     raddr1;
    logic [DW-1:0]     rdata1;
    logic [AW-1:0]     raddr2;
    logic [DW-1:0]     rdata2;
    logic              dbg_valid;
    logic              dbg_ready;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;
    logic              dbg_done;
    logic [N*DW-1:0]   regfile;
    logic [31:0]       wr_count;

    int checks = 0;
    int errors = 0;

    gpr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .dbg_done(dbg_done), .regfile(regfile),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents, write count, and outstanding debug requests.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    logic [DW-1:0] ref_mem [N];
    logic [31:0]   ref_count;
    logic          ref_done;
    req_t          pend_q[$];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (wen && waddr == a && a != 0) return wdata;
        return (a == 0) ? '0 : ref_mem[a];
    endfunction

    function automatic logic [N*DW-1:0] ref_flat();
        logic [N*DW-1:0] f;
        f = '0;
        for (int i = 1; i < N; i++) f[i*DW +: DW] = ref_mem[i];
        return f;
    endfunction

    function automatic logic ref_ready();
        return rst_n && (pend_q.size() == 0);
    endfunction

    task automatic model_edge();
        req_t r;
        bit   was_pending;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
            ref_count = 0;
            ref_done  = 1'b0;
            pend_q.delete();
        end else begin
            was_pending = (pend_q.size() != 0);
            ref_done = 1'b0;
            if (wen && waddr != 0) begin
                ref_mem[waddr] = wdata;
                ref_count++;
            end
            if (was_pending && !wen) begin
                r = pend_q.pop_front();
                if (r.a != 0) begin
                    ref_mem[r.a] = r.d;
                    ref_count++;
                end
                ref_done = 1'b1;
            end else if (!was_pending && dbg_valid) begin
                r.a = dbg_addr;
                r.d = dbg_data;
                pend_q.push_back(r);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen = 1'b0; waddr = '0; wdata = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (dbg_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got %b expected 0", dbg_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (regfile !== '0) begin
            errors++; $display("FAIL reset_regfile: got %h expected all zero", regfile);
        end
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_release: got %b expected 1", dbg_ready);
        end
        checks++;
        if (wr_count !== 32'd0) begin
            errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
        end
        checks++;
        if (dbg_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", dbg_done);
        end
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++; $display("FAIL reset_rdata1: got %h expected 0", rdata1);
        end
    endtask

    task automatic test_core_write();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL core_bypass: got %h expected deadbeef", rdata1);
        end
        tick();
        idle_inputs();
        raddr1 = 5'd5;
        #1;
        checks++;
        if (regfile[5*DW +: DW] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL core_entry5: got %h expected deadbeef", regfile[5*DW +: DW]);
        end
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL core_read_storage: got %h expected deadbeef", rdata1);
        end
        checks++;
        if (wr_count !== 32'd1) begin
            errors++; $display("FAIL core_wr_count: got %0d expected 1", wr_count);
        end
    endtask

    task automatic test_x0_write();
        wen = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++; $display("FAIL x0_bypass: got %h expected 0", rdata1);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (regfile[0 +: DW] !== 32'd0) begin
            errors++; $display("FAIL x0_entry: got %h expected 0", regfile[0 +: DW]);
        end
        checks++;
        if (wr_count !== 32'd1) begin
            errors++; $display("FAIL x0_wr_count: got %0d expected 1", wr_count);
        end
    endtask

    task automatic test_dbg_write();
        dbg_valid = 1'b1; dbg_addr = 5'd10; dbg_data = 32'hA5A5A5A5; raddr2 = 5'd10;
        tick();
        dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
        #1;
        checks++;
        if (dbg_ready !== 1'b0 || dbg_done !== 1'b0) begin
            errors++; $display("FAIL dbg_accept: got ready=%b done=%b expected ready=0 done=0", dbg_ready, dbg_done);
        end
        checks++;
        if (rdata2 !== 32'd0) begin
            errors++; $display("FAIL dbg_no_bypass: got %h expected 0", rdata2);
        end
        tick();
        checks++;
        if (regfile[10*DW +: DW] !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL dbg_entry10: got %h expected a5a5a5a5", regfile[10*DW +: DW]);
        end
        checks++;
        if (dbg_done !== 1'b1 || dbg_ready !== 1'b1) begin
            errors++; $display("FAIL dbg_done_pulse: got done=%b ready=%b expected 1 1", dbg_done, dbg_ready);
        end
        tick();
        checks++;
        if (dbg_done !== 1'b0) begin
            errors++; $display("FAIL dbg_done_clear: got %b expected 0", dbg_done);
        end
        checks++;
        if (wr_count !== 32'd2) begin
            errors++; $display("FAIL dbg_wr_count: got %0d expected 2", wr_count);
        end
        idle_inputs();
    endtask

    task automatic test_dbg_stall();
        logic [31:0] start;
        start = wr_count;
        dbg_valid = 1'b1; dbg_addr = 5'd20; dbg_data = 32'h0BADF00D;
        tick();
        dbg_valid = 1'b1; dbg_addr = 5'd21; dbg_data = 32'h11111111;
        for (int k = 0; k < 3; k++) begin
            wen = 1'b1; waddr = 5'd3; wdata = 32'h3000 + k;
            tick();
            checks++;
            if (dbg_done !== 1'b0 || dbg_ready !== 1'b0) begin
                errors++; $display("FAIL stall_pending[%0d]: got done=%b ready=%b expected 0 0", k, dbg_done, dbg_ready);
            end
        end
        wen = 1'b0; dbg_valid = 1'b0;
        tick();
        checks++;
        if (dbg_done !== 1'b1) begin
            errors++; $display("FAIL stall_commit_done: got %b expected 1", dbg_done);
        end
        checks++;
        if (regfile[3*DW +: DW] !== 32'h3002 || regfile[20*DW +: DW] !== 32'h0BADF00D) begin
            errors++; $display("FAIL stall_entries: got x3=%h x20=%h expected 3002 0badf00d",
                               regfile[3*DW +: DW], regfile[20*DW +: DW]);
        end
        checks++;
        if (regfile[21*DW +: DW] !== 32'd0) begin
            errors++; $display("FAIL stall_ignored: got %h expected 0", regfile[21*DW +: DW]);
        end
        checks++;
        if (wr_count !== start + 32'd4) begin
            errors++; $display("FAIL stall_wr_count: got %0d expected %0d", wr_count, start + 32'd4);
        end
        idle_inputs();
    endtask

    task automatic test_dbg_reset();
        dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'hCAFEF00D;
        tick();
        dbg_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (regfile[7*DW +: DW] !== 32'd0 || dbg_done !== 1'b0) begin
            errors++; $display("FAIL dbgrst_discard: got x7=%h done=%b expected 0 0", regfile[7*DW +: DW], dbg_done);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++; $display("FAIL dbgrst_ready: got %b expected 1", dbg_ready);
        end
        tick();
        checks++;
        if (dbg_done !== 1'b0 || regfile[7*DW +: DW] !== 32'd0) begin
            errors++; $display("FAIL dbgrst_no_done: got done=%b x7=%h expected 0 0", dbg_done, regfile[7*DW +: DW]);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        dbg_valid = 1'b1; dbg_addr = 5'd12; dbg_data = 32'h12121212;
        tick();
        dbg_addr = 5'd13; dbg_data = 32'h13131313;
        tick();
        checks++;
        if (dbg_done !== 1'b1 || dbg_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first_done: got done=%b ready=%b expected 1 1", dbg_done, dbg_ready);
        end
        tick();
        dbg_valid = 1'b0;
        checks++;
        if (dbg_done !== 1'b0 || dbg_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept: got done=%b ready=%b expected 0 0", dbg_done, dbg_ready);
        end
        tick();
        checks++;
        if (regfile[12*DW +: DW] !== 32'h12121212 || regfile[13*DW +: DW] !== 32'h13131313 || dbg_done !== 1'b1) begin
            errors++; $display("FAIL b2b_entries: got x12=%h x13=%h done=%b expected 12121212 13131313 1",
                               regfile[12*DW +: DW], regfile[13*DW +: DW], dbg_done);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wen       = ($urandom_range(0, 99) < 50);
            waddr     = AW'($urandom_range(0, N-1));
            wdata     = $urandom;
            raddr1    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, N-1));
            raddr2    = AW'($urandom_range(0, N-1));
            dbg_valid = ($urandom_range(0, 99) < 40);
            dbg_addr  = AW'($urandom_range(0, N-1));
            dbg_data  = $urandom;
            #1;
            checks++;
            if (rdata1 !== ref_read(raddr1) || rdata2 !== ref_read(raddr2)) begin
                errors++; $display("FAIL rand_read[%0d]: got %h %h expected %h %h",
                                   c, rdata1, rdata2, ref_read(raddr1), ref_read(raddr2));
            end
            tick();
            checks++;
            if (regfile !== ref_flat()) begin
                errors++; $display("FAIL rand_regfile[%0d]: storage differs from model", c);
            end
            checks++;
            if (wr_count !== ref_count || dbg_done !== ref_done || dbg_ready !== ref_ready()) begin
                errors++; $display("FAIL rand_status[%0d]: got cnt=%0d done=%b ready=%b expected %0d %b %b",
                                   c, wr_count, dbg_done, dbg_ready, ref_count, ref_done, ref_ready());
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_core_write();
        test_x0_write();
        test_dbg_write();
        test_dbg_stall();
        test_dbg_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
